// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the arbiter, the two cache requesters and the shared memory bus.
// The slave modport is the arbiter's view; master is the view of everything around it.
`timescale 1ns/1ps
interface mem_bus_arbiter_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
);
  logic                      icache_busreq,  dcache_busreq;
  logic                      icache_busidle, dcache_busidle;
  logic                      icache_busgrant, dcache_busgrant;

  logic                      icache_bus_reqcyc, icache_bus_respack;
  logic [BUS_DATA_WIDTH-1:0] icache_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  icache_bus_reqtag;
  logic                      dcache_bus_reqcyc, dcache_bus_respack;
  logic [BUS_DATA_WIDTH-1:0] dcache_bus_req;
  logic [BUS_TAG_WIDTH-1:0]  dcache_bus_reqtag;

  logic                      icache_bus_respcyc, icache_bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] icache_bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  icache_bus_resptag;
  logic                      dcache_bus_respcyc, dcache_bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] dcache_bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  dcache_bus_resptag;

  logic                      bus_reqcyc, bus_respack;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_respcyc, bus_reqack;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

  modport slave (
    input  icache_busreq, dcache_busreq, icache_busidle, dcache_busidle,
    input  icache_bus_reqcyc, icache_bus_respack, icache_bus_req, icache_bus_reqtag,
    input  dcache_bus_reqcyc, dcache_bus_respack, dcache_bus_req, dcache_bus_reqtag,
    input  bus_respcyc, bus_reqack, bus_resp, bus_resptag,
    output icache_busgrant, dcache_busgrant,
    output icache_bus_respcyc, icache_bus_reqack, icache_bus_resp, icache_bus_resptag,
    output dcache_bus_respcyc, dcache_bus_reqack, dcache_bus_resp, dcache_bus_resptag,
    output bus_reqcyc, bus_respack, bus_req, bus_reqtag
  );

  modport master (
    output icache_busreq, dcache_busreq, icache_busidle, dcache_busidle,
    output icache_bus_reqcyc, icache_bus_respack, icache_bus_req, icache_bus_reqtag,
    output dcache_bus_reqcyc, dcache_bus_respack, dcache_bus_req, dcache_bus_reqtag,
    output bus_respcyc, bus_reqack, bus_resp, bus_resptag,
    input  icache_busgrant, dcache_busgrant,
    input  icache_bus_respcyc, icache_bus_reqack, icache_bus_resp, icache_bus_resptag,
    input  dcache_bus_respcyc, dcache_bus_reqack, dcache_bus_resp, dcache_bus_resptag,
    input  bus_reqcyc, bus_respack, bus_req, bus_reqtag
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter: data cache has priority, a starvation counter forces an
// instruction-cache grant after STARVE_LIMIT contested data-cache wins.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input logic               clk,
  input logic               reset,
  mem_bus_arbiter_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StOwnI, StOwnD, StRelease} state_e;

  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       grant_i_q, grant_i_d;
  logic       grant_d_q, grant_d_d;
  logic       own_i, own_d;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle, StRelease: begin
        state_d = StIdle;
        if (bus_io.icache_busreq && (!bus_io.dcache_busreq || starve_q == StarveLimit)) begin
          state_d  = StOwnI;
          starve_d = '0;
        end else if (bus_io.dcache_busreq) begin
          state_d = StOwnD;
          // Reaching here with icache waiting implies starve_q < limit, so no overflow.
          if (bus_io.icache_busreq) starve_d = starve_q + 8'd1;
        end
      end
      StOwnI: if (bus_io.icache_busidle && !bus_io.bus_respcyc) state_d = StRelease;
      StOwnD: if (bus_io.dcache_busidle && !bus_io.bus_respcyc) state_d = StRelease;
      default: state_d = StIdle;
    endcase
    grant_i_d = (state_d == StOwnI);
    grant_d_d = (state_d == StOwnD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      starve_q  <= '0;
      grant_i_q <= 1'b0;
      grant_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      grant_i_q <= grant_i_d;
      grant_d_q <= grant_d_d;
    end
  end

  assign own_i = (state_q == StOwnI);
  assign own_d = (state_q == StOwnD);

  assign bus_io.icache_busgrant = grant_i_q;
  assign bus_io.dcache_busgrant = grant_d_q;

  // Request mux: the owner drives the shared bus, otherwise it is parked at zero.
  assign bus_io.bus_reqcyc  = own_i ? bus_io.icache_bus_reqcyc :
                              own_d ? bus_io.dcache_bus_reqcyc : 1'b0;
  assign bus_io.bus_respack = own_i ? bus_io.icache_bus_respack :
                              own_d ? bus_io.dcache_bus_respack : 1'b0;
  assign bus_io.bus_req     = own_i ? bus_io.icache_bus_req :
                              own_d ? bus_io.dcache_bus_req : {BUS_DATA_WIDTH{1'b0}};
  assign bus_io.bus_reqtag  = own_i ? bus_io.icache_bus_reqtag :
                              own_d ? bus_io.dcache_bus_reqtag : {BUS_TAG_WIDTH{1'b0}};

  // Response demux: only the owner sees bus responses.
  assign bus_io.icache_bus_respcyc = own_i & bus_io.bus_respcyc;
  assign bus_io.icache_bus_reqack  = own_i & bus_io.bus_reqack;
  assign bus_io.icache_bus_resp    = own_i ? bus_io.bus_resp : {BUS_DATA_WIDTH{1'b0}};
  assign bus_io.icache_bus_resptag = own_i ? bus_io.bus_resptag : {BUS_TAG_WIDTH{1'b0}};
  assign bus_io.dcache_bus_respcyc = own_d & bus_io.bus_respcyc;
  assign bus_io.dcache_bus_reqack  = own_d & bus_io.bus_reqack;
  assign bus_io.dcache_bus_resp    = own_d ? bus_io.bus_resp : {BUS_DATA_WIDTH{1'b0}};
  assign bus_io.dcache_bus_resptag = own_d ? bus_io.bus_resptag : {BUS_TAG_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// compared against an owner/starvation-count reference model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int unsigned DW    = 64;
  localparam int unsigned TW    = 13;
  localparam int unsigned LIMIT = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bif ();

  mem_bus_arbiter #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bif)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bif.icache_busreq = 0; bif.dcache_busreq = 0;
    bif.icache_busidle = 0; bif.dcache_busidle = 0;
    bif.icache_bus_reqcyc = 0; bif.icache_bus_respack = 0;
    bif.icache_bus_req = '0; bif.icache_bus_reqtag = '0;
    bif.dcache_bus_reqcyc = 0; bif.dcache_bus_respack = 0;
    bif.dcache_bus_req = '0; bif.dcache_bus_reqtag = '0;
    bif.bus_respcyc = 0; bif.bus_reqack = 0; bif.bus_resp = '0; bif.bus_resptag = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One arbitration round: request, sample the grant, release the owner, sample RELEASE.
  task automatic run_round(input bit ir, input bit dr, output bit gi, output bit gd,
                           output bit rel_any);
    @(negedge clk);
    bif.icache_busreq = ir; bif.dcache_busreq = dr;
    bif.icache_busidle = 0; bif.dcache_busidle = 0;
    @(posedge clk); #1;
    gi = bif.icache_busgrant; gd = bif.dcache_busgrant;
    @(negedge clk);
    bif.icache_busidle = 1; bif.dcache_busidle = 1;
    @(posedge clk); #1;
    rel_any = bif.icache_busgrant | bif.dcache_busgrant;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bif.icache_busreq = 1; bif.icache_bus_reqcyc = 1; bif.icache_bus_req = 64'h55;
    bif.bus_respcyc = 1; bif.bus_resp = 64'h77; bif.bus_reqack = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b00) begin
      n_fail++; $display("FAIL reset_grants: got %b want 00", {bif.icache_busgrant,
                                                               bif.dcache_busgrant});
    end
    n_checks++;
    if ({bif.bus_reqcyc, bif.bus_respack, bif.bus_req, bif.bus_reqtag} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got reqcyc=%b req=%h want 0", bif.bus_reqcyc,
                         bif.bus_req);
    end
    n_checks++;
    if ({bif.icache_bus_respcyc, bif.icache_bus_reqack, bif.icache_bus_resp,
         bif.dcache_bus_respcyc, bif.dcache_bus_reqack, bif.dcache_bus_resp} !== '0) begin
      n_fail++; $display("FAIL reset_resp: got iresp=%h dresp=%h want 0", bif.icache_bus_resp,
                         bif.dcache_bus_resp);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_dcache_grant();
    do_reset();
    @(negedge clk);
    bif.dcache_busreq = 1; bif.dcache_bus_reqcyc = 1;
    bif.dcache_bus_req = 64'hDEAD_BEEF; bif.dcache_bus_reqtag = 13'h5;
    bif.icache_bus_req = 64'hFFFF;
    @(posedge clk); #1;
    n_checks++;
    if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b01) begin
      n_fail++; $display("FAIL dgrant_latency: got i,d=%b want 01", {bif.icache_busgrant,
                                                                     bif.dcache_busgrant});
    end
    n_checks++;
    if (bif.bus_req !== 64'hDEAD_BEEF || bif.bus_reqtag !== 13'h5 || bif.bus_reqcyc !== 1'b1)
    begin
      n_fail++; $display("FAIL dgrant_route: got req=%h tag=%h want deadbeef/5", bif.bus_req,
                         bif.bus_reqtag);
    end
    n_checks++;
    if (bif.icache_bus_resp !== '0) begin
      n_fail++; $display("FAIL dgrant_iresp: got %h want 0", bif.icache_bus_resp);
    end
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk);
    bif.icache_busreq = 1; bif.dcache_busreq = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b01) begin
      n_fail++; $display("FAIL prio_first: got i,d=%b want 01", {bif.icache_busgrant,
                                                                 bif.dcache_busgrant});
    end
    @(negedge clk);
    bif.dcache_busreq = 0; bif.dcache_busidle = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({bif.icache_busgrant, bif.dcache_busgrant, bif.bus_reqcyc} !== 3'b000) begin
      n_fail++; $display("FAIL prio_release: got i,d,cyc=%b want 000",
                         {bif.icache_busgrant, bif.dcache_busgrant, bif.bus_reqcyc});
    end
    @(negedge clk);
    bif.dcache_busidle = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({bif.icache_busgrant, bif.dcache_busgrant} !== 2'b10) begin
      n_fail++; $display("FAIL prio_second: got i,d=%b want 10", {bif.icache_busgrant,
                                                                  bif.dcache_busgrant});
    end
  endtask

  task automatic test_starvation();
    bit gi, gd, rel;
    bit exp_i;
    do_reset();
    for (int k = 0; k < 2 * (LIMIT + 1); k++) begin
      run_round(1'b1, 1'b1, gi, gd, rel);
      exp_i = ((k % (LIMIT + 1)) == LIMIT);
      n_checks++;
      if (gi !== exp_i || gd !== !exp_i || rel !== 1'b0) begin
        n_fail++; $display("FAIL starve_round%0d: got i,d,rel=%b%b%b want %b%b0", k, gi, gd,
                           rel, exp_i, !exp_i);
      end
    end
  endtask

  task automatic test_resp_routing();
    do_reset();
    @(negedge clk);
    bif.dcache_busreq = 1; bif.dcache_bus_reqcyc = 1;
    @(posedge clk); #1;
    @(negedge clk);
    bif.dcache_busreq = 0; bif.dcache_busidle = 1;
    bif.bus_respcyc = 1; bif.bus_reqack = 1; bif.bus_resp = 64'h1234; bif.bus_resptag = 13'h7;
    #1;
    n_checks++;
    if (bif.dcache_bus_resp !== 64'h1234 || bif.dcache_bus_resptag !== 13'h7 ||
        bif.dcache_bus_respcyc !== 1'b1 || bif.dcache_bus_reqack !== 1'b1) begin
      n_fail++; $display("FAIL resp_owner: got resp=%h tag=%h want 1234/7",
                         bif.dcache_bus_resp, bif.dcache_bus_resptag);
    end
    n_checks++;
    if ({bif.icache_bus_respcyc, bif.icache_bus_reqack, bif.icache_bus_resp} !== '0) begin
      n_fail++; $display("FAIL resp_nonowner: got cyc=%b resp=%h want 0",
                         bif.icache_bus_respcyc, bif.icache_bus_resp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bif.dcache_busgrant !== 1'b1) begin
      n_fail++; $display("FAIL resp_idle_hold: got grant=%b want 1", bif.dcache_busgrant);
    end
    @(negedge clk);
    bif.bus_respcyc = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({bif.dcache_busgrant, bif.dcache_bus_reqack, bif.dcache_bus_resp} !== '0) begin
      n_fail++; $display("FAIL resp_release: got grant=%b ack=%b want 0", bif.dcache_busgrant,
                         bif.dcache_bus_reqack);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    bif.icache_busreq = 1; bif.icache_bus_reqcyc = 1; bif.icache_bus_req = 64'hA5;
    @(posedge clk); #1;
    n_checks++;
    if (bif.icache_busgrant !== 1'b1 || bif.bus_reqcyc !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: got grant=%b cyc=%b want 1/1", bif.icache_busgrant,
                         bif.bus_reqcyc);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bif.icache_busgrant, bif.bus_reqcyc, bif.bus_req} !== '0) begin
      n_fail++; $display("FAIL areset_drop: got grant=%b cyc=%b req=%h want 0",
                         bif.icache_busgrant, bif.bus_reqcyc, bif.bus_req);
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bif.icache_busgrant, bif.dcache_busgrant, bif.bus_reqcyc} !== 3'b000) begin
      n_fail++; $display("FAIL areset_idle: got i,d,cyc=%b want 000",
                         {bif.icache_busgrant, bif.dcache_busgrant, bif.bus_reqcyc});
    end
  endtask

  task automatic test_icache_only();
    bit gi, gd, rel;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_round(1'b1, 1'b1, gi, gd, rel);
      n_checks++;
      if ({gi, gd} !== 2'b01) begin
        n_fail++; $display("FAIL ionly_preload%0d: got i,d=%b%b want 01", k, gi, gd);
      end
    end
    run_round(1'b1, 1'b0, gi, gd, rel);
    n_checks++;
    if ({gi, gd} !== 2'b10) begin
      n_fail++; $display("FAIL ionly_grant: got i,d=%b%b want 10", gi, gd);
    end
    // Uncontested dcache wins must not advance the counter.
    for (int k = 0; k < 10; k++) begin
      run_round(1'b0, 1'b1, gi, gd, rel);
      n_checks++;
      if ({gi, gd} !== 2'b01) begin
        n_fail++; $display("FAIL donly_grant%0d: got i,d=%b%b want 01", k, gi, gd);
      end
    end
    for (int k = 0; k <= LIMIT; k++) begin
      run_round(1'b1, 1'b1, gi, gd, rel);
      n_checks++;
      if (gi !== (k == LIMIT) || gd !== (k != LIMIT)) begin
        n_fail++; $display("FAIL ionly_count%0d: got i,d=%b%b want %b%b", k, gi, gd,
                           k == LIMIT, k != LIMIT);
      end
    end
  endtask

  task automatic test_random();
    int owner;   // 0 = nobody, 1 = icache, 2 = dcache
    int starve;
    logic [DW+TW+1:0] exp_rq, got_rq, exp_ir, got_ir, exp_dr, got_dr, rsp;
    do_reset();
    owner = 0;
    starve = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bif.icache_busreq      = ($urandom_range(0, 2) == 0);
      bif.dcache_busreq      = ($urandom_range(0, 1) == 0);
      bif.icache_busidle     = ($urandom_range(0, 2) == 0);
      bif.dcache_busidle     = ($urandom_range(0, 2) == 0);
      bif.bus_respcyc        = ($urandom_range(0, 2) == 0);
      bif.bus_reqack         = 1'($urandom);
      bif.icache_bus_reqcyc  = 1'($urandom);
      bif.icache_bus_respack = 1'($urandom);
      bif.dcache_bus_reqcyc  = 1'($urandom);
      bif.dcache_bus_respack = 1'($urandom);
      bif.icache_bus_req     = {$urandom, $urandom};
      bif.dcache_bus_req     = {$urandom, $urandom};
      bif.bus_resp           = {$urandom, $urandom};
      bif.icache_bus_reqtag  = TW'($urandom);
      bif.dcache_bus_reqtag  = TW'($urandom);
      bif.bus_resptag        = TW'($urandom);
      #1;
      rsp = {bif.bus_respcyc, bif.bus_reqack, bif.bus_resptag, bif.bus_resp};
      exp_rq = (owner == 1) ? {bif.icache_bus_reqcyc, bif.icache_bus_respack,
                               bif.icache_bus_reqtag, bif.icache_bus_req} :
               (owner == 2) ? {bif.dcache_bus_reqcyc, bif.dcache_bus_respack,
                               bif.dcache_bus_reqtag, bif.dcache_bus_req} : '0;
      exp_ir = (owner == 1) ? rsp : '0;
      exp_dr = (owner == 2) ? rsp : '0;
      got_rq = {bif.bus_reqcyc, bif.bus_respack, bif.bus_reqtag, bif.bus_req};
      got_ir = {bif.icache_bus_respcyc, bif.icache_bus_reqack, bif.icache_bus_resptag,
                bif.icache_bus_resp};
      got_dr = {bif.dcache_bus_respcyc, bif.dcache_bus_reqack, bif.dcache_bus_resptag,
                bif.dcache_bus_resp};
      n_checks++;
      if (bif.icache_busgrant !== (owner == 1) || bif.dcache_busgrant !== (owner == 2)) begin
        n_fail++; $display("FAIL rand_grant c%0d: got i,d=%b%b want owner %0d", c,
                           bif.icache_busgrant, bif.dcache_busgrant, owner);
      end
      n_checks++;
      if (got_rq !== exp_rq) begin
        n_fail++; $display("FAIL rand_reqmux c%0d: got %h want %h", c, got_rq, exp_rq);
      end
      n_checks++;
      if (got_ir !== exp_ir) begin
        n_fail++; $display("FAIL rand_iresp c%0d: got %h want %h", c, got_ir, exp_ir);
      end
      n_checks++;
      if (got_dr !== exp_dr) begin
        n_fail++; $display("FAIL rand_dresp c%0d: got %h want %h", c, got_dr, exp_dr);
      end
      @(posedge clk);
      // Reference: an owner gives the bus back on idle without a response in flight; the
      // cycle after that nobody owns it and arbitration runs on that cycle's requests.
      if (owner == 1) begin
        if (bif.icache_busidle && !bif.bus_respcyc) owner = 0;
      end else if (owner == 2) begin
        if (bif.dcache_busidle && !bif.bus_respcyc) owner = 0;
      end else if (bif.icache_busreq && (!bif.dcache_busreq || starve == LIMIT)) begin
        owner = 1;
        starve = 0;
      end else if (bif.dcache_busreq) begin
        owner = 2;
        if (bif.icache_busreq) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_dcache_grant();
    test_priority();
    test_starvation();
    test_resp_routing();
    test_async_reset();
    test_icache_only();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
